// File: rtl/ka_decode_dat_pipe_pkg.sv
// Shared types and the ctrl-field routing rule for the ka data decode pipe.
package ka_decode_pkg;

    localparam int unsigned CTRL_DROP = 0;

    typedef enum logic [1:0] {RT_DROP, RT_SK, RT_LK} route_e;
    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_e;

    // ctrl is zero-extended into 32 bits; its top bit selects the long-key path.
    function automatic route_e ka_route(input logic [31:0] ctrl, input int unsigned ctrl_w);
        if (ctrl == 32'(CTRL_DROP)) return RT_DROP;
        if (ctrl[5'(ctrl_w - 1)]) return RT_LK;
        return RT_SK;
    endfunction

endpackage

// File: rtl/ka_decode_dat_pipe_if.sv
// Stream bundle: ka input beat plus the sk and lk output queues.
interface ka_decode_dat_pipe_if #(
    parameter int DATA_W = 196
);
    logic              t_ka_valid;
    logic              t_ka_ready;
    logic [DATA_W-1:0] t_ka_dat;
    logic              i_sk_valid;
    logic              i_sk_ready;
    logic [DATA_W-1:0] i_sk_dat;
    logic              i_lk_valid;
    logic              i_lk_ready;
    logic [DATA_W-1:0] i_lk_dat;

    modport slave (
        input  t_ka_valid, t_ka_dat, i_sk_ready, i_lk_ready,
        output t_ka_ready, i_sk_valid, i_sk_dat, i_lk_valid, i_lk_dat
    );

    modport master (
        output t_ka_valid, t_ka_dat, i_sk_ready, i_lk_ready,
        input  t_ka_ready, i_sk_valid, i_sk_dat, i_lk_valid, i_lk_dat
    );
endinterface

// File: rtl/ka_decode_dat_pipe_fifo.sv
// Synchronous FIFO with registered head; the caller only pushes when there is room.
module ka_decode_fifo #(
    parameter int DATA_W = 196,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    output logic              o_full,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            // Simultaneous push and pop leaves occupancy unchanged, even when full.
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/ka_decode_dat_pipe.sv
// Registered ka beat classifier: one hold stage feeding sk/lk output queues.
// Optional KA_DECODE_DAT_STATS_EN adds saturating route/drop counters with stat_clr.
module ka_decode_dat_pipe
    import ka_decode_pkg::*;
#(
    parameter int DATA_W = 196,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ka_decode_dat_pipe_if.slave   bus,
    output logic [CTRL_W-1:0]     k_ctrl,
    output logic                  drop_pulse
`ifdef KA_DECODE_DAT_STATS_EN
    ,
    output logic [31:0]           stat_sk_cnt,
    output logic [31:0]           stat_lk_cnt,
    output logic [31:0]           stat_drop_cnt,
    input  logic                  stat_clr
`endif
);
    hold_e             r_state, w_state_nxt;
    logic [DATA_W-1:0] r_hold_dat;
    logic [CTRL_W-1:0] w_ctrl;
    route_e            w_route;
    logic              w_sk_full, w_lk_full, w_sk_room, w_lk_room;
    logic              w_drain, w_ready, w_accept;
    logic              w_sk_push, w_lk_push, w_drop;
    logic [CTRL_W-1:0] r_k_ctrl;
    logic              r_drop_pulse;

    assign w_ctrl  = r_hold_dat[DATA_W-1 -: CTRL_W];
    assign w_route = ka_route(32'(w_ctrl), CTRL_W);

    // A full queue still takes the held beat when its consumer pops this cycle.
    assign w_sk_room = !w_sk_full || bus.i_sk_ready;
    assign w_lk_room = !w_lk_full || bus.i_lk_ready;

    assign w_drain = (r_state == HOLD_FULL) &&
                     ((w_route == RT_DROP) ||
                      (w_route == RT_SK && w_sk_room) ||
                      (w_route == RT_LK && w_lk_room));

    assign w_sk_push = w_drain && (w_route == RT_SK);
    assign w_lk_push = w_drain && (w_route == RT_LK);
    assign w_drop    = w_drain && (w_route == RT_DROP);
    assign w_accept  = bus.t_ka_valid && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= HOLD_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            HOLD_EMPTY: begin
                w_ready = 1'b1;
                if (bus.t_ka_valid) w_state_nxt = HOLD_FULL;
            end
            HOLD_FULL: begin
                w_ready = w_drain;
                if (w_drain && !bus.t_ka_valid) w_state_nxt = HOLD_EMPTY;
            end
            default: w_state_nxt = HOLD_EMPTY;
        endcase
    end

    assign bus.t_ka_ready = w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_dat   <= '0;
            r_k_ctrl     <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            if (w_accept) r_hold_dat <= bus.t_ka_dat;
            if (w_drain)  r_k_ctrl   <= w_ctrl;
            r_drop_pulse <= w_drop;
        end
    end

    assign k_ctrl     = r_k_ctrl;
    assign drop_pulse = r_drop_pulse;

    ka_decode_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sk_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_sk_push),
        .i_push_dat(r_hold_dat),
        .o_full    (w_sk_full),
        .i_pop     (bus.i_sk_ready),
        .o_valid   (bus.i_sk_valid),
        .o_head    (bus.i_sk_dat)
    );

    ka_decode_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lk_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_lk_push),
        .i_push_dat(r_hold_dat),
        .o_full    (w_lk_full),
        .i_pop     (bus.i_lk_ready),
        .o_valid   (bus.i_lk_valid),
        .o_head    (bus.i_lk_dat)
    );

`ifdef KA_DECODE_DAT_STATS_EN
    logic [31:0] r_sk_cnt, r_lk_cnt, r_drop_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sk_cnt   <= '0;
            r_lk_cnt   <= '0;
            r_drop_cnt <= '0;
        end else if (stat_clr) begin
            r_sk_cnt   <= '0;
            r_lk_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_sk_push) r_sk_cnt   <= sat_inc(r_sk_cnt);
            if (w_lk_push) r_lk_cnt   <= sat_inc(r_lk_cnt);
            if (w_drop)    r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    assign stat_sk_cnt   = r_sk_cnt;
    assign stat_lk_cnt   = r_lk_cnt;
    assign stat_drop_cnt = r_drop_cnt;
`endif
endmodule
